// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD bus writer: state encodings,
// command codes and default timing.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4
  } lcd_state_e;

  localparam int          RS_BIT    = 8;
  localparam logic [7:0]  CMD_CLEAR = 8'h01;
  localparam logic [7:0]  CMD_HOME  = 8'h02;
  localparam logic [7:0]  HOME_MASK = 8'hFE;

  localparam int DEF_SETUP_CYC     = 4;
  localparam int DEF_PULSE_CYC     = 25;
  localparam int DEF_HOLD_CYC      = 2;
  localparam int DEF_EXEC_CYC      = 4000;
  localparam int DEF_LONG_EXEC_CYC = 164000;
  localparam int DEF_CNT_W         = 18;

  // Clear and Return Home (0x02/0x03, bit 0 is don't-care) need the long wait.
  function automatic logic is_long_cmd(input logic [8:0] w);
    return !w[RS_BIT] && ((w[7:0] == CMD_CLEAR) || ((w[7:0] & HOME_MASK) == CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Up-counter shared by all timed states: cleared on every state change,
// done when the count reaches the terminal value (N-1).
module lcd_delay_counter
  import lcd_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign done_o = (cnt_q == term_i);

endmodule

// File: rtl/lcd_bus_writer.sv
// Accepts 9-bit LCD words over valid/ready and drives the 8-bit parallel bus
// with setup / enable-pulse / hold / execution-wait timing.
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC     = DEF_SETUP_CYC,
  parameter int PULSE_CYC     = DEF_PULSE_CYC,
  parameter int HOLD_CYC      = DEF_HOLD_CYC,
  parameter int EXEC_CYC      = DEF_EXEC_CYC,
  parameter int LONG_EXEC_CYC = DEF_LONG_EXEC_CYC,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [8:0] data_i,
  input  logic       data_valid_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_e_o,
  output logic [7:0] lcd_db_o
);

  localparam logic [CNT_W-1:0] SETUP_TERM = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_TERM = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_TERM  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_TERM  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_TERM  = CNT_W'(LONG_EXEC_CYC - 1);

  lcd_state_e       state_q;
  logic             rs_q;
  logic [7:0]       db_q;
  logic             e_q;
  logic [CNT_W-1:0] term;
  logic             cnt_done;
  logic             cnt_clr;

  // The captured word stays on rs/db until the next transfer, so the wait
  // length can be decoded from it throughout WAIT.
  always_comb begin
    term = '0;
    case (state_q)
      ST_SETUP: term = SETUP_TERM;
      ST_PULSE: term = PULSE_TERM;
      ST_HOLD:  term = HOLD_TERM;
      ST_WAIT:  term = is_long_cmd({rs_q, db_q}) ? LONG_TERM : EXEC_TERM;
      default:  term = '0;
    endcase
  end

  // Held at zero in IDLE; every terminal count is also a state change.
  assign cnt_clr = (state_q == ST_IDLE) || cnt_done;

  lcd_delay_counter #(
    .CNT_W(CNT_W)
  ) u_delay (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr),
    .term_i(term),
    .done_o(cnt_done)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      rs_q    <= 1'b0;
      db_q    <= 8'h00;
      e_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          e_q <= 1'b0;
          if (data_valid_i) begin
            rs_q    <= data_i[RS_BIT];
            db_q    <= data_i[7:0];
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_done) begin
            e_q     <= 1'b1;
            state_q <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (cnt_done) begin
            e_q     <= 1'b0;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt_done) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_done) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          e_q     <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready_o  = (state_q == ST_IDLE) && !rst_i;
  assign busy_o   = (state_q != ST_IDLE) && !rst_i;
  assign lcd_rs_o = rs_q;
  assign lcd_db_o = db_q;
  assign lcd_e_o  = e_q;
  assign lcd_rw_o = 1'b0;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Directed bench for lcd_bus_writer: a full-timing instance (execution waits
// shortened) plus a minimum-timing instance, with a word scoreboard on the E strobe.
module tb_lcd_bus_writer;

  localparam int A_SETUP = 4;
  localparam int A_PULSE = 25;
  localparam int A_HOLD  = 2;
  localparam int A_EXEC  = 400;
  localparam int A_LONG  = 1640;
  localparam int A_SHORT_TOTAL = A_SETUP + A_PULSE + A_HOLD + A_EXEC;
  localparam int A_LONG_TOTAL  = A_SETUP + A_PULSE + A_HOLD + A_LONG;

  logic clk;
  logic rst_a, rst_b;
  logic [8:0] data;
  logic valid;
  bit   sel_b;

  logic rdy_a, busy_a, rs_a, rw_a, e_a;
  logic [7:0] db_a;
  logic rdy_b, busy_b, rs_b, rw_b, e_b;
  logic [7:0] db_b;

  logic rdy_m, busy_m, rs_m, rw_m, e_m;
  logic [7:0] db_m;

  int checks = 0;
  int failures = 0;
  int pops = 0;
  int stab_err = 0;
  int rw_err = 0;

  logic [8:0] sb[$];

  lcd_bus_writer #(
    .SETUP_CYC(A_SETUP), .PULSE_CYC(A_PULSE), .HOLD_CYC(A_HOLD),
    .EXEC_CYC(A_EXEC), .LONG_EXEC_CYC(A_LONG), .CNT_W(18)
  ) dut_a (
    .clk_i(clk), .rst_i(rst_a), .data_i(data), .data_valid_i(valid && !sel_b),
    .ready_o(rdy_a), .busy_o(busy_a), .lcd_rs_o(rs_a), .lcd_rw_o(rw_a),
    .lcd_e_o(e_a), .lcd_db_o(db_a)
  );

  lcd_bus_writer #(
    .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1),
    .EXEC_CYC(1), .LONG_EXEC_CYC(2), .CNT_W(4)
  ) dut_b (
    .clk_i(clk), .rst_i(rst_b), .data_i(data), .data_valid_i(valid && sel_b),
    .ready_o(rdy_b), .busy_o(busy_b), .lcd_rs_o(rs_b), .lcd_rw_o(rw_b),
    .lcd_e_o(e_b), .lcd_db_o(db_b)
  );

  assign rdy_m  = sel_b ? rdy_b  : rdy_a;
  assign busy_m = sel_b ? busy_b : busy_a;
  assign rs_m   = sel_b ? rs_b   : rs_a;
  assign rw_m   = sel_b ? rw_b   : rw_a;
  assign e_m    = sel_b ? e_b    : e_a;
  assign db_m   = sel_b ? db_b   : db_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and bus-stability monitor for instance A.
  logic       e_prev_a = 1'b0;
  logic       stab_on = 1'b0;
  logic [8:0] cur_word = '0;
  always @(negedge clk) begin
    if (rw_a !== 1'b0 || rw_b !== 1'b0) rw_err++;
    if (rst_a) begin
      stab_on  = 1'b0;
      e_prev_a = 1'b0;
    end else begin
      if (e_a && !e_prev_a) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_strobe", 32'(sb.size()), 32'd1);
        end else begin
          cur_word = sb.pop_front();
          pops++;
          chk("sb_rs", 32'(rs_a), 32'(cur_word[8]));
          chk("sb_db", 32'(db_a), 32'(cur_word[7:0]));
          stab_on = 1'b1;
        end
      end
      if (stab_on) begin
        if ({rs_a, db_a} !== cur_word) stab_err++;
        if (rdy_a) stab_on = 1'b0;
      end
      e_prev_a = e_a;
    end
  end

  // One complete write on the selected instance, with data_i toggled while busy.
  task automatic xfer(input logic [8:0] w, input int rise_exp, input int hi_exp,
                      input int total_exp, input string tag);
    int g, n, rise, hi;
    g = 0;
    while (!rdy_m && g < 300000) begin
      @(posedge clk); #1; g++;
    end
    chk({tag, "_ready_before"}, 32'(rdy_m), 32'd1);
    data = w;
    valid = 1'b1;
    if (!sel_b) sb.push_back(w);
    @(posedge clk); #1;
    valid = 1'b0;
    chk({tag, "_busy_after_xfer"}, 32'({busy_m, rdy_m}), 32'b10);
    n = 0; rise = -1; hi = 0;
    while (n < 200000) begin
      @(posedge clk); #1;
      n++;
      data = 9'($urandom);
      if (e_m) begin
        if (rise < 0) rise = n;
        hi++;
      end
      if (rdy_m) break;
    end
    chk({tag, "_e_rise"}, 32'(rise), 32'(rise_exp));
    chk({tag, "_e_high"}, 32'(hi), 32'(hi_exp));
    chk({tag, "_ready_latency"}, 32'(n), 32'(total_exp));
    chk({tag, "_rs_kept"}, 32'(rs_m), 32'(w[8]));
    chk({tag, "_db_kept"}, 32'(db_m), 32'(w[7:0]));
  endtask

  initial begin
    logic [8:0] w4 [3];
    int idx, cyc, pops0, g;
    bit will_xfer;

    rst_a = 1'b1; rst_b = 1'b1; valid = 1'b0; data = '0; sel_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_a", 32'(rdy_a), 32'd0);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_bus_a", 32'({e_a, rs_a, db_a}), 32'd0);
    chk("rst_bus_b", 32'({e_b, rs_b, db_b, rdy_b}), 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready_a", 32'({rdy_a, busy_a}), 32'b10);
    chk("post_rst_ready_b", 32'({rdy_b, busy_b}), 32'b10);

    // Data word, commands with long and short waits, Return Home, all-zero word.
    xfer(9'h141, A_SETUP, A_PULSE, A_SHORT_TOTAL, "data_A");
    xfer(9'h001, A_SETUP, A_PULSE, A_LONG_TOTAL, "cmd_clear");
    xfer(9'h101, A_SETUP, A_PULSE, A_SHORT_TOTAL, "data_01");
    xfer(9'h003, A_SETUP, A_PULSE, A_LONG_TOTAL, "cmd_home3");
    xfer(9'h000, A_SETUP, A_PULSE, A_SHORT_TOTAL, "word_zero");
    xfer(9'h004, A_SETUP, A_PULSE, A_SHORT_TOTAL, "cmd_04");

    // Valid held high with three words queued.
    w4[0] = 9'h148; w4[1] = 9'h069; w4[2] = 9'h14C;
    pops0 = pops;
    idx = 0; cyc = 0;
    data = w4[0]; valid = 1'b1;
    while (idx < 3 && cyc < 20000) begin
      will_xfer = rdy_a;
      @(posedge clk); #1;
      cyc++;
      if (will_xfer) begin
        sb.push_back(w4[idx]);
        idx++;
        if (idx < 3) data = w4[idx];
        else begin
          valid = 1'b0;
          data = 9'($urandom);
        end
      end
    end
    valid = 1'b0;
    g = 0;
    while (!rdy_a && g < 20000) begin
      @(posedge clk); #1; g++;
    end
    chk("queue_transfers", 32'(idx), 32'd3);
    chk("queue_cycles", 32'(cyc), 32'(2 * (A_SHORT_TOTAL + 1) + 1));
    chk("queue_strobes", 32'(pops - pops0), 32'd3);
    chk("queue_sb_empty", 32'(sb.size()), 32'd0);

    // Reset in the middle of the enable pulse.
    data = 9'h155; valid = 1'b1; sb.push_back(9'h155);
    @(posedge clk); #1;
    valid = 1'b0;
    g = 0;
    while (!e_a && g < 100) begin
      @(posedge clk); #1; g++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("mid_pulse_e_high", 32'(e_a), 32'd1);
    rst_a = 1'b1;
    #0;
    chk("rst_mid_ready", 32'({rdy_a, busy_a}), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("rst_mid_e_low", 32'({e_a, rdy_a, busy_a}), 32'd0);
    end
    rst_a = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_release", 32'({rdy_a, busy_a, e_a}), 32'b100);
    chk("rst_mid_bus_clear", 32'({rs_a, db_a}), 32'd0);
    chk("rst_mid_sb_empty", 32'(sb.size()), 32'd0);
    xfer(9'h130, A_SETUP, A_PULSE, A_SHORT_TOTAL, "after_rst");

    // Minimum timing instance: N=1 everywhere, long wait of 2.
    sel_b = 1'b1;
    xfer(9'h141, 1, 1, 4, "small_data");
    xfer(9'h002, 1, 1, 5, "small_home");
    xfer(9'h0FF, 1, 1, 4, "small_cmd");
    sel_b = 1'b0;

    chk("bus_stable", 32'(stab_err), 32'd0);
    chk("rw_zero", 32'(rw_err), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
